sw_cmd_sequencer: RTL and testbench

//  Upstream command stage of vector_adder_top: turns the 16-bit switch word into RAM0

---
 rtl/cmd_pkg.sv | 34 +++
 rtl/sw_sync.sv | 27 ++
 rtl/sw_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_sw_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared encodings for the switch command sequencer: switch-word field positions,
// mode codes and the command FSM state enum.
package cmd_pkg;

  localparam int MODE_HI = 15;
  localparam int MODE_LO = 14;
  localparam int ADDR_HI = 13;
  localparam int ADDR_LO = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_INC   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PEND     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_INC_RD   = 3'd3,
    ST_INC_WAIT = 3'd4,
    ST_INC_WR   = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // Modes with bit 1 set (write, increment) are the ones that modify RAM0.
  function automatic logic is_cmd_mode(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/sw_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low clear.
module sw_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two back-to-back flops; r_meta may go metastable, r_sync is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sw_cmd_sequencer.sv
// Switch-word command sequencer: one-shot RAM0 write/increment and result-RAM display reads.
// Build option INCR_SATURATE_EN: increment saturates at all-ones instead of wrapping.
module sw_cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 4,
  parameter int RES_W      = 5,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       i_sw,
  input  logic              i_adder_busy,
  output logic [ADDR_W-1:0] o_ram0_addr,
  output logic              o_ram0_we,
  output logic [DATA_W-1:0] o_ram0_wdata,
  input  logic [DATA_W-1:0] i_ram0_rdata,
  output logic [ADDR_W-1:0] o_res_addr,
  input  logic [RES_W-1:0]  i_res_rdata,
  output logic [RES_W-1:0]  o_disp_val,
  output logic              o_disp_valid,
  output logic              o_cmd_busy,
  output logic              o_cmd_done
);

  localparam logic [1:0] LAT_M1 = 2'(RAM_RD_LAT - 1);

  logic [15:0]       w_sw_s;
  logic [1:0]        w_mode;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_trig;
  logic              w_rd_issue;
  logic [DATA_W-1:0] w_inc_val;
  state_e            w_next;

  state_e            r_state;
  logic [1:0]        r_prev_mode;
  logic              r_inc;
  logic [1:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_ram0_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_pipe_addr [RAM_RD_LAT+1];
  logic [RAM_RD_LAT:0] r_pipe_vld;
  logic [RES_W-1:0]  r_disp_val;
  logic              r_disp_valid;

  sw_sync #(.W(16)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_sw),
    .o_q   (w_sw_s)
  );

  assign w_mode     = w_sw_s[MODE_HI:MODE_LO];
  assign w_addr     = w_sw_s[ADDR_HI:ADDR_LO];
  assign w_data     = w_sw_s[DATA_HI:DATA_LO];
  assign w_trig     = (r_state == ST_IDLE) && is_cmd_mode(w_mode) && (w_mode != r_prev_mode);
  assign w_rd_issue = (r_state == ST_IDLE) && (w_mode == MODE_READ);

`ifdef INCR_SATURATE_EN
  assign w_inc_val = (i_ram0_rdata == {DATA_W{1'b1}}) ? i_ram0_rdata
                   : i_ram0_rdata + {{(DATA_W-1){1'b0}}, 1'b1};
`else
  assign w_inc_val = i_ram0_rdata + {{(DATA_W-1){1'b0}}, 1'b1};
`endif

  // Command FSM next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_trig)           w_next = ST_IDLE;
        else if (i_adder_busy) w_next = ST_PEND;
        else if (w_mode[0])    w_next = ST_INC_RD;
        else                   w_next = ST_WRITE;
      end
      ST_PEND: begin
        if (i_adder_busy) w_next = ST_PEND;
        else if (r_inc)   w_next = ST_INC_RD;
        else              w_next = ST_WRITE;
      end
      ST_WRITE:    w_next = ST_DONE;
      ST_INC_RD:   w_next = ST_INC_WAIT;
      ST_INC_WAIT: begin
        if (r_wait_cnt == LAT_M1) w_next = ST_INC_WR;
        else                      w_next = ST_INC_WAIT;
      end
      ST_INC_WR:   w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // FSM state, command capture and registered RAM0/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prev_mode <= 2'b00;
      r_inc       <= 1'b0;
      r_wait_cnt  <= 2'd0;
      r_ram0_addr <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_prev_mode <= w_mode;
      if (w_trig) begin
        r_ram0_addr <= w_addr;
        r_wdata     <= w_data;
        r_inc       <= w_mode[0];
      end else if ((r_state == ST_INC_WAIT) && (w_next == ST_INC_WR)) begin
        r_wdata <= w_inc_val;
      end
      r_wait_cnt <= (r_state == ST_INC_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
      r_we       <= (w_next == ST_WRITE) || (w_next == ST_INC_WR);
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (w_next == ST_DONE);
    end
  end

  // Read pipeline: stage 0 is the presented address, stage RAM_RD_LAT lines up with i_res_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RAM_RD_LAT; i++) r_pipe_addr[i] <= '0;
      r_pipe_vld   <= '0;
      r_disp_val   <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      if (w_rd_issue) r_pipe_addr[0] <= w_addr;
      r_pipe_vld[0] <= w_rd_issue;
      for (int i = 1; i <= RAM_RD_LAT; i++) begin
        r_pipe_addr[i] <= r_pipe_addr[i-1];
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
      end
      if (w_rd_issue && r_pipe_vld[RAM_RD_LAT]) r_disp_val <= i_res_rdata;
      r_disp_valid <= w_rd_issue && r_pipe_vld[RAM_RD_LAT] &&
                      (r_pipe_addr[RAM_RD_LAT] == w_addr);
    end
  end

  assign o_ram0_addr  = r_ram0_addr;
  assign o_ram0_we    = r_we;
  assign o_ram0_wdata = r_wdata;
  assign o_res_addr   = r_pipe_addr[0];
  assign o_disp_val   = r_disp_val;
  assign o_disp_valid = r_disp_valid;
  assign o_cmd_busy   = r_busy;
  assign o_cmd_done   = r_done;

endmodule

// File: tb/tb_sw_cmd_sequencer.sv
// Self-checking bench for sw_cmd_sequencer: vector table, hand sequences and a random phase
// against a memory-level reference model. Honours INCR_SATURATE_EN for increment expectations.
module tb_sw_cmd_sequencer;

  localparam int AW  = 10;
  localparam int DW  = 4;
  localparam int RW  = 5;
  localparam int LAT = 1;
`ifdef INCR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   sw = 16'h0000;
  logic          adder_busy = 1'b0;
  logic [AW-1:0] ram0_addr, res_addr;
  logic          ram0_we, disp_valid, cmd_busy, cmd_done;
  logic [DW-1:0] ram0_wdata, ram0_rdata;
  logic [RW-1:0] res_rdata, disp_val;

  sw_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RES_W(RW), .RAM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(sw), .i_adder_busy(adder_busy),
    .o_ram0_addr(ram0_addr), .o_ram0_we(ram0_we), .o_ram0_wdata(ram0_wdata),
    .i_ram0_rdata(ram0_rdata), .o_res_addr(res_addr), .i_res_rdata(res_rdata),
    .o_disp_val(disp_val), .o_disp_valid(disp_valid), .o_cmd_busy(cmd_busy),
    .o_cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM0 and result RAM, both with LAT-cycle read latency.
  logic [DW-1:0] mem0 [0:1023];
  logic [RW-1:0] resm [0:1023];
  logic [DW-1:0] rd0_pipe [0:LAT-1];
  logic [RW-1:0] rdr_pipe [0:LAT-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem0[pl_addr] <= pl_data;
    else if (ram0_we) mem0[ram0_addr] <= ram0_wdata;
    rd0_pipe[0] <= mem0[ram0_addr];
    rdr_pipe[0] <= resm[res_addr];
    for (int i = 1; i < LAT; i++) begin
      rd0_pipe[i] <= rd0_pipe[i-1];
      rdr_pipe[i] <= rdr_pipe[i-1];
    end
  end
  assign ram0_rdata = rd0_pipe[LAT-1];
  assign res_rdata  = rdr_pipe[LAT-1];

  int we_cnt = 0, we_cyc = 0, done_cnt = 0;
  logic [AW-1:0] we_addr = '0;
  always @(negedge clk) begin
    if (ram0_we) begin
      we_cnt  = we_cnt + 1;
      we_cyc  = cyc;
      we_addr = ram0_addr;
    end
    if (cmd_done) done_cnt = done_cnt + 1;
  end

  int total = 0, bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] inc_ref(input logic [DW-1:0] v);
    int x;
    x = int'(v) + 1;
    if (x > 15) x = SAT ? 15 : 0;
    return DW'(x);
  endfunction

  // Applies one command; latency is measured from the sw change, or from busy release.
  task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int busy_hold, output int lat, output int nwe, output int ndone);
    int we0, dn0, t0;
    we0 = we_cnt; dn0 = done_cnt;
    if (busy_hold > 0) adder_busy = 1'b1;
    sw = {m, a, d};
    t0 = cyc;
    if (busy_hold > 0) begin
      tick(busy_hold);
      adder_busy = 1'b0;
      t0 = cyc;
    end
    for (int i = 0; i < 40 && done_cnt == dn0; i++) @(negedge clk);
    tick(3);
    lat = we_cyc - t0; nwe = we_cnt - we0; ndone = done_cnt - dn0;
  endtask

  typedef struct {
    logic [1:0]    m;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] pre;
    int            busy;
    int            lat;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];
  logic [DW-1:0] ref_mem [0:15];

  initial begin
    int lat, nwe, ndone, we0, t0, op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    for (int i = 0; i < 1024; i++) resm[i] = RW'($urandom);
    resm[5] = 5'h12;
    resm[6] = 5'h07;

    // Write: 2 sync cycles + 1; increment: 2 sync + 2 + LAT; after busy release: 1 / 2+LAT.
    vecs[0] = '{2'b10, 10'd8,     4'h3, 4'h0, 0, 3,       4'h3};
    vecs[1] = '{2'b11, 10'd8,     4'h0, 4'h3, 0, 4 + LAT, 4'h4};
    vecs[2] = '{2'b11, 10'd8,     4'h0, 4'hF, 0, 4 + LAT, SAT ? 4'hF : 4'h0};
    vecs[3] = '{2'b10, 10'h3FF,   4'hA, 4'h5, 0, 3,       4'hA};
    vecs[4] = '{2'b10, 10'd8,     4'h6, 4'h1, 6, 1,       4'h6};
    vecs[5] = '{2'b11, 10'd0,     4'h0, 4'h7, 5, 2 + LAT, 4'h8};
    vecs[6] = '{2'b11, 10'h155,   4'h9, 4'hE, 0, 4 + LAT, 4'hF};

    tick(5);
    check("rst ram0_we", 32'(ram0_we), 32'd0);
    check("rst ram0_addr", 32'(ram0_addr), 32'd0);
    check("rst ram0_wdata", 32'(ram0_wdata), 32'd0);
    check("rst res_addr", 32'(res_addr), 32'd0);
    check("rst disp_val", 32'(disp_val), 32'd0);
    check("rst disp_valid", 32'(disp_valid), 32'd0);
    check("rst cmd_busy", 32'(cmd_busy), 32'd0);
    check("rst cmd_done", 32'(cmd_done), 32'd0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 7; i++) begin
      preload(vecs[i].a, vecs[i].pre);
      run_cmd(vecs[i].m, vecs[i].a, vecs[i].d, vecs[i].busy, lat, nwe, ndone);
      check($sformatf("vec%0d we count", i), 32'(nwe), 32'd1);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d done", i), 32'(ndone), 32'd1);
      check($sformatf("vec%0d we addr", i), 32'(we_addr), 32'(vecs[i].a));
      check($sformatf("vec%0d mem", i), 32'(mem0[vecs[i].a]), 32'(vecs[i].exp));
      we0 = we_cnt;
      tick(i == 0 ? 100 : 20);
      check($sformatf("vec%0d hold no retrigger", i), 32'(we_cnt - we0), 32'd0);
      sw = 16'h0000;
      tick(4);
    end

    // Pending write: no we while busy, second edge during pending is dropped.
    preload(10'd20, 4'h0);
    preload(10'd21, 4'h0);
    we0 = we_cnt;
    adder_busy = 1'b1;
    sw = {2'b10, 10'd20, 4'h5};
    tick(6);
    check("pend no we", 32'(we_cnt - we0), 32'd0);
    check("pend cmd_busy", 32'(cmd_busy), 32'd1);
    sw = 16'h0000;
    tick(3);
    sw = {2'b10, 10'd21, 4'h9};
    tick(4);
    adder_busy = 1'b0;
    t0 = cyc;
    tick(30);
    check("pend one we", 32'(we_cnt - we0), 32'd1);
    check("pend latency", 32'(we_cyc - t0), 32'd1);
    check("pend first addr", 32'(mem0[20]), 32'h5);
    check("pend dropped edge", 32'(mem0[21]), 32'h0);
    check("pend idle busy", 32'(cmd_busy), 32'd0);
    sw = 16'h0000;
    tick(4);

    // Display read: res_addr one cycle after swS, disp_val LAT+1 after res_addr.
    sw = {2'b01, 10'd5, 4'h0};
    t0 = cyc;
    tick(3);
    check("rd res_addr", 32'(res_addr), 32'd5);
    tick(1);
    check("rd valid early", 32'(disp_valid), 32'd0);
    tick(1);
    check("rd valid", 32'(disp_valid), 32'd1);
    check("rd val", 32'(disp_val), 32'h12);
    sw = {2'b01, 10'd6, 4'h0};
    tick(3);
    check("rd2 res_addr", 32'(res_addr), 32'd6);
    check("rd2 stale invalid", 32'(disp_valid), 32'd0);
    tick(2);
    check("rd2 valid", 32'(disp_valid), 32'd1);
    check("rd2 val", 32'(disp_val), 32'h07);
    sw = 16'h0000;
    tick(5);
    check("rd leave valid", 32'(disp_valid), 32'd0);
    check("rd leave hold", 32'(disp_val), 32'h07);

    // Reset during INC_WAIT abandons the increment.
    preload(10'd8, 4'h9);
    we0 = we_cnt;
    sw = {2'b11, 10'd8, 4'h0};
    tick(4);
    rst_n = 1'b0;
    sw = 16'h0000;
    tick(3);
    check("mid-rst cmd_busy", 32'(cmd_busy), 32'd0);
    check("mid-rst ram0_we", 32'(ram0_we), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("mid-rst no we", 32'(we_cnt - we0), 32'd0);
    check("mid-rst mem kept", 32'(mem0[8]), 32'h9);

    // Random phase against the reference memory.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = DW'($urandom);
      preload(AW'(i), ref_mem[i]);
    end
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      a  = AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      if (op == 2) begin
        sw = {2'b01, a, 4'h0};
        tick(8);
        check($sformatf("rnd%0d read valid", k), 32'(disp_valid), 32'd1);
        check($sformatf("rnd%0d read val", k), 32'(disp_val), 32'(resm[a]));
      end else begin
        run_cmd(op == 1 ? 2'b11 : 2'b10, a, d,
                ($urandom_range(0, 3) == 0) ? $urandom_range(4, 8) : 0, lat, nwe, ndone);
        ref_mem[a[3:0]] = (op == 1) ? inc_ref(ref_mem[a[3:0]]) : d;
        check($sformatf("rnd%0d we count", k), 32'(nwe), 32'd1);
        check($sformatf("rnd%0d mem", k), 32'(mem0[a]), 32'(ref_mem[a[3:0]]));
      end
      sw = 16'h0000;
      tick(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
